// File: rtl/rob_multi_commit.sv
// Reorder buffer: in-order allocate, out-of-order completion, in-order multi-lane retire,
// single-cycle squash of everything younger than a mispredicting branch.
module rob_multi_commit #(
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned TAG_W    = $clog2(DEPTH),
  parameter int unsigned PREG_W   = 7,
  parameter int unsigned NUM_WB   = 3,
  parameter int unsigned RETIRE_W = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alloc_valid,
  output logic                       alloc_ready,
  input  logic [PREG_W-1:0]          alloc_pd_new,
  input  logic [PREG_W-1:0]          alloc_pd_old,
  input  logic [31:0]                alloc_pc,
  output logic [TAG_W-1:0]           alloc_tag,
  input  logic [NUM_WB-1:0]          wb_valid,
  input  logic [NUM_WB*TAG_W-1:0]    wb_tag,
  input  logic                       flush_valid,
  input  logic [TAG_W-1:0]           flush_tag,
  output logic [RETIRE_W-1:0]        retire_valid,
  output logic [RETIRE_W*PREG_W-1:0] retire_pd_old,
  output logic [RETIRE_W*PREG_W-1:0] retire_pd_new,
  output logic [RETIRE_W*32-1:0]     retire_pc,
  output logic [TAG_W:0]             count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned CNT_W = TAG_W + 1;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0]  head_q, tail_q, head_d, tail_d;
  logic [DEPTH-1:0]  valid_q, complete_q, valid_d, complete_d;
  logic [PREG_W-1:0] pd_new_q [DEPTH];
  logic [PREG_W-1:0] pd_old_q [DEPTH];
  logic [31:0]       pc_q     [DEPTH];

  logic [TAG_W-1:0]  head_idx, tail_idx, flush_age, lane_idx, wb_idx, entry_age;
  logic [DEPTH-1:0]  squash, retire_clr;
  logic [CNT_W-1:0]  retire_n;
  logic              lane_ok;
  logic              alloc_fire;

  assign head_idx    = head_q[TAG_W-1:0];
  assign tail_idx    = tail_q[TAG_W-1:0];
  assign count       = tail_q - head_q;
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign alloc_ready = !full && !flush_valid;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign alloc_tag   = tail_idx;
  assign flush_age   = flush_tag - head_idx;

  // Squash mask: live entries strictly younger than the mispredicting branch.
  always_comb begin
    squash    = '0;
    entry_age = '0;
    for (int j = 0; j < DEPTH; j++) begin
      entry_age = TAG_W'(j) - head_idx;
      squash[j] = flush_valid && (entry_age > flush_age) && (CNT_W'(entry_age) < count);
    end
  end

  // Retire lanes: contiguous run of valid+complete entries from head, never past a flushing branch.
  always_comb begin
    retire_valid  = '0;
    retire_pd_old = '0;
    retire_pd_new = '0;
    retire_pc     = '0;
    retire_clr    = '0;
    retire_n      = '0;
    lane_idx      = '0;
    lane_ok       = 1'b1;
    for (int k = 0; k < RETIRE_W; k++) begin
      lane_idx = head_idx + TAG_W'(k);
      lane_ok  = lane_ok && valid_q[lane_idx] && complete_q[lane_idx] &&
                 (!flush_valid || (TAG_W'(k) <= flush_age));
      retire_valid[k]                      = lane_ok;
      retire_pd_old[k*PREG_W +: PREG_W]    = pd_old_q[lane_idx];
      retire_pd_new[k*PREG_W +: PREG_W]    = pd_new_q[lane_idx];
      retire_pc[k*32 +: 32]                = pc_q[lane_idx];
      if (lane_ok) begin
        retire_clr[lane_idx] = 1'b1;
        retire_n             = retire_n + CNT_W'(1);
      end
    end
  end

  // Next-state for pointers and per-entry status: writeback, then squash/retire clears, then allocate.
  always_comb begin
    valid_d    = valid_q;
    complete_d = complete_q;
    wb_idx     = '0;
    head_d     = head_q + retire_n;
    if (flush_valid) begin
      tail_d = head_q + CNT_W'(flush_age) + CNT_W'(1);
    end else begin
      tail_d = tail_q + CNT_W'(alloc_fire);
    end
    for (int i = 0; i < NUM_WB; i++) begin
      wb_idx = wb_tag[i*TAG_W +: TAG_W];
      if (wb_valid[i] && valid_q[wb_idx]) begin
        complete_d[wb_idx] = 1'b1;
      end
    end
    valid_d    = valid_d    & ~(squash | retire_clr);
    complete_d = complete_d & ~(squash | retire_clr);
    if (alloc_fire) begin
      valid_d[tail_idx]    = 1'b1;
      complete_d[tail_idx] = 1'b0;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      complete_q <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      valid_q    <= valid_d;
      complete_q <= complete_d;
    end
  end

  // Payload storage, written only on allocation; status bits gate its use.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pd_new_q[tail_idx] <= alloc_pd_new;
      pd_old_q[tail_idx] <= alloc_pd_old;
      pc_q[tail_idx]     <= alloc_pc;
    end
  end

endmodule

// File: tb/tb_rob_multi_commit.sv
// Self-checking bench for rob_multi_commit: directed scenarios plus randomized traffic
// against a program-order queue model of the buffer.
module tb_rob_multi_commit;

  localparam int DEPTH    = 32;
  localparam int TAG_W    = 5;
  localparam int PREG_W   = 7;
  localparam int NUM_WB   = 3;
  localparam int RETIRE_W = 2;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [PREG_W-1:0]          alloc_pd_new;
  logic [PREG_W-1:0]          alloc_pd_old;
  logic [31:0]                alloc_pc;
  logic [TAG_W-1:0]           alloc_tag;
  logic [NUM_WB-1:0]          wb_valid;
  logic [NUM_WB*TAG_W-1:0]    wb_tag;
  logic                       flush_valid;
  logic [TAG_W-1:0]           flush_tag;
  logic [RETIRE_W-1:0]        retire_valid;
  logic [RETIRE_W*PREG_W-1:0] retire_pd_old;
  logic [RETIRE_W*PREG_W-1:0] retire_pd_new;
  logic [RETIRE_W*32-1:0]     retire_pc;
  logic [TAG_W:0]             count;
  logic                       empty;
  logic                       full;

  always #5 clk = ~clk;

  rob_multi_commit #(
    .DEPTH(DEPTH), .TAG_W(TAG_W), .PREG_W(PREG_W), .NUM_WB(NUM_WB), .RETIRE_W(RETIRE_W)
  ) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old), .alloc_pc(alloc_pc),
    .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .flush_valid(flush_valid), .flush_tag(flush_tag),
    .retire_valid(retire_valid), .retire_pd_old(retire_pd_old),
    .retire_pd_new(retire_pd_new), .retire_pc(retire_pc),
    .count(count), .empty(empty), .full(full)
  );

  // Reference model: live instructions in program order, oldest first.
  typedef struct {
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
    logic [31:0]       pc;
    bit                done;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  function automatic int m_pos(int tag);
    return (tag - m_head + DEPTH) % DEPTH;
  endfunction

  // Number of in-order completed instructions that leave this cycle.
  function automatic int m_retire_n(bit fl, int fpos);
    int n = 0;
    while (n < RETIRE_W && n < q.size() && q[n].done && (!fl || n <= fpos)) n++;
    return n;
  endfunction

  task automatic idle();
    reset        = 1'b0;
    alloc_valid  = 1'b0;
    alloc_pd_new = '0;
    alloc_pd_old = '0;
    alloc_pc     = '0;
    wb_valid     = '0;
    wb_tag       = '0;
    flush_valid  = 1'b0;
    flush_tag    = '0;
  endtask

  // Advance the model by the currently driven inputs, clock the DUT, return inputs to idle.
  task automatic tick();
    bit   fl;
    bit   fire;
    int   fpos;
    int   n;
    int   p;
    ent_t e;
    if (reset) begin
      q.delete();
      m_head = 0;
    end else begin
      fl   = flush_valid;
      fpos = m_pos(int'(flush_tag));
      assert (!fl || fpos < q.size()) else $error("flush_tag names no live entry");
      fire = alloc_valid && (q.size() < DEPTH) && !fl;
      n    = m_retire_n(fl, fpos);
      for (int i = 0; i < NUM_WB; i++) begin
        if (wb_valid[i]) begin
          p = m_pos(int'(wb_tag[i*TAG_W +: TAG_W]));
          if (p < q.size() && (!fl || p <= fpos)) q[p].done = 1'b1;
        end
      end
      if (fl) while (q.size() > fpos + 1) void'(q.pop_back());
      for (int k = 0; k < n; k++) void'(q.pop_front());
      m_head = (m_head + n) % DEPTH;
      if (fire) begin
        e.pd_new = alloc_pd_new;
        e.pd_old = alloc_pd_old;
        e.pc     = alloc_pc;
        e.done   = 1'b0;
        q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", empty); else n_pass++;
    n_checks++; if (count !== 6'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b1) $display("FAIL reset_alloc_ready got %0b want 1", alloc_ready); else n_pass++;
    n_checks++; if (alloc_tag !== 5'd0) $display("FAIL reset_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
    n_checks++; if (retire_valid !== 2'b00) $display("FAIL reset_retire_valid got %b want 00", retire_valid); else n_pass++;
    n_checks++; if (full !== 1'b0) $display("FAIL reset_full got %0b want 0", full); else n_pass++;
  endtask

  task automatic test_inorder_retire();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid  = 1'b1;
      alloc_pd_old = PREG_W'(10 + i);
      alloc_pd_new = PREG_W'(40 + i);
      alloc_pc     = 32'h100 + 32'(4 * i);
      #1;
      n_checks++; if (alloc_tag !== 5'(i)) $display("FAIL inorder_alloc_tag got %0d want %0d", alloc_tag, i); else n_pass++;
      tick();
    end
    wb_valid = 3'b011;
    wb_tag   = {5'd0, 5'd0, 5'd1};
    tick();
    n_checks++; if (retire_valid !== 2'b11) $display("FAIL inorder_rv01 got %b want 11", retire_valid); else n_pass++;
    n_checks++; if (retire_pd_old[6:0] !== 7'd10) $display("FAIL inorder_pdold0 got %0d want 10", retire_pd_old[6:0]); else n_pass++;
    n_checks++; if (retire_pd_old[13:7] !== 7'd11) $display("FAIL inorder_pdold1 got %0d want 11", retire_pd_old[13:7]); else n_pass++;
    n_checks++; if (count !== 6'd4) $display("FAIL inorder_count_before got %0d want 4", count); else n_pass++;
    tick();
    n_checks++; if (count !== 6'd2) $display("FAIL inorder_count_after got %0d want 2", count); else n_pass++;
    wb_valid = 3'b001;
    wb_tag   = {5'd0, 5'd0, 5'd3};
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (retire_valid !== 2'b00) $display("FAIL inorder_tag2_blocks got %b want 00", retire_valid); else n_pass++;
      tick();
    end
    wb_valid = 3'b100;
    wb_tag   = {5'd2, 5'd0, 5'd0};
    tick();
    n_checks++; if (retire_valid !== 2'b11) $display("FAIL inorder_rv23 got %b want 11", retire_valid); else n_pass++;
    n_checks++; if (retire_pd_old !== {7'd13, 7'd12}) $display("FAIL inorder_pdold23 got %h want %h", retire_pd_old, {7'd13, 7'd12}); else n_pass++;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL inorder_empty got %0b want 1", empty); else n_pass++;
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      alloc_valid  = 1'b1;
      alloc_pd_old = PREG_W'(i);
      tick();
    end
    n_checks++; if (full !== 1'b1) $display("FAIL full_flag got %0b want 1", full); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_alloc_ready got %0b want 0", alloc_ready); else n_pass++;
    n_checks++; if (count !== 6'd32) $display("FAIL full_count got %0d want 32", count); else n_pass++;
    alloc_valid = 1'b1;
    tick();
    n_checks++; if (count !== 6'd32) $display("FAIL full_overflow_count got %0d want 32", count); else n_pass++;
    n_checks++; if (alloc_tag !== 5'd0) $display("FAIL full_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
    wb_valid = 3'b001;
    wb_tag   = '0;
    tick();
    n_checks++; if (retire_valid !== 2'b01) $display("FAIL full_retire got %b want 01", retire_valid); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b0) $display("FAIL full_ready_same_cycle got %0b want 0", alloc_ready); else n_pass++;
    tick();
    n_checks++; if (full !== 1'b0) $display("FAIL full_after_retire got %0b want 0", full); else n_pass++;
    n_checks++; if (alloc_ready !== 1'b1) $display("FAIL full_ready_after got %0b want 1", alloc_ready); else n_pass++;
    n_checks++; if (count !== 6'd31) $display("FAIL full_count_after got %0d want 31", count); else n_pass++;
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      alloc_valid = 1'b1;
      tick();
      wb_valid = 3'b001;
      wb_tag   = {10'd0, 5'(i)};
      tick();
    end
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL wrap_preadvance_empty got %0b want 1", empty); else n_pass++;
    n_checks++; if (alloc_tag !== 5'd30) $display("FAIL wrap_preadvance_tag got %0d want 30", alloc_tag); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1;
      alloc_pc    = 32'h2000 + 32'(i);
      #1;
      n_checks++; if (alloc_tag !== 5'((30 + i) % DEPTH)) $display("FAIL wrap_alloc_tag got %0d want %0d", alloc_tag, (30 + i) % DEPTH); else n_pass++;
      tick();
    end
    wb_valid = 3'b111;
    wb_tag   = {5'd0, 5'd31, 5'd30};
    tick();
    n_checks++; if (retire_valid !== 2'b11) $display("FAIL wrap_rv_first got %b want 11", retire_valid); else n_pass++;
    n_checks++; if (retire_pc !== {32'h2001, 32'h2000}) $display("FAIL wrap_pc_first got %h want %h", retire_pc, {32'h2001, 32'h2000}); else n_pass++;
    wb_valid = 3'b001;
    wb_tag   = {10'd0, 5'd1};
    tick();
    n_checks++; if (retire_valid !== 2'b11) $display("FAIL wrap_rv_second got %b want 11", retire_valid); else n_pass++;
    n_checks++; if (retire_pc !== {32'h2003, 32'h2002}) $display("FAIL wrap_pc_second got %h want %h", retire_pc, {32'h2003, 32'h2002}); else n_pass++;
    tick();
    n_checks++; if (empty !== 1'b1) $display("FAIL wrap_empty got %0b want 1", empty); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1;
      alloc_pc    = 32'h3000 + 32'(i);
      tick();
    end
    flush_valid = 1'b1;
    flush_tag   = 5'd3;
    wb_valid    = 3'b001;
    wb_tag      = {10'd0, 5'd5};
    alloc_valid = 1'b1;
    #1;
    n_checks++; if (alloc_ready !== 1'b0) $display("FAIL flush_alloc_ready got %0b want 0", alloc_ready); else n_pass++;
    tick();
    n_checks++; if (count !== 6'd4) $display("FAIL flush_count got %0d want 4", count); else n_pass++;
    n_checks++; if (alloc_tag !== 5'd4) $display("FAIL flush_alloc_tag got %0d want 4", alloc_tag); else n_pass++;
    alloc_valid = 1'b1;
    alloc_pc    = 32'h3100;
    tick();
    n_checks++; if (count !== 6'd5) $display("FAIL flush_realloc_count got %0d want 5", count); else n_pass++;
    wb_valid = 3'b111;
    wb_tag   = {5'd2, 5'd1, 5'd0};
    tick();
    n_checks++; if (retire_valid !== 2'b11) $display("FAIL flush_rv01 got %b want 11", retire_valid); else n_pass++;
    wb_valid = 3'b001;
    wb_tag   = {10'd0, 5'd3};
    tick();
    n_checks++; if (retire_pc !== {32'h3003, 32'h3002}) $display("FAIL flush_pc23 got %h want %h", retire_pc, {32'h3003, 32'h3002}); else n_pass++;
    tick();
    n_checks++; if (retire_valid !== 2'b00) $display("FAIL flush_new_tag4_incomplete got %b want 00", retire_valid); else n_pass++;
    n_checks++; if (count !== 6'd1) $display("FAIL flush_count_tail got %0d want 1", count); else n_pass++;
    wb_valid = 3'b010;
    wb_tag   = {5'd0, 5'd4, 5'd0};
    tick();
    n_checks++; if (retire_valid !== 2'b01) $display("FAIL flush_tag4_retire got %b want 01", retire_valid); else n_pass++;
    n_checks++; if (retire_pc[31:0] !== 32'h3100) $display("FAIL flush_tag4_pc got %h want 3100", retire_pc[31:0]); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      alloc_valid = 1'b1;
      tick();
    end
    reset    = 1'b1;
    wb_valid = 3'b111;
    wb_tag   = {5'd2, 5'd1, 5'd0};
    tick();
    n_checks++; if (count !== 6'd0) $display("FAIL midreset_count got %0d want 0", count); else n_pass++;
    n_checks++; if (retire_valid !== 2'b00) $display("FAIL midreset_rv got %b want 00", retire_valid); else n_pass++;
    n_checks++; if (alloc_tag !== 5'd0) $display("FAIL midreset_alloc_tag got %0d want 0", alloc_tag); else n_pass++;
    tick();
    n_checks++; if (retire_valid !== 2'b00) $display("FAIL midreset_rv_later got %b want 00", retire_valid); else n_pass++;
  endtask

  // Randomized alloc/wb/flush traffic; alternating phases fill and drain the buffer.
  task automatic test_random();
    bit            fl;
    int            fpos;
    int            n;
    int            t;
    bit            fill_phase;
    logic [1:0]    exp_rv;
    do_reset();
    for (int cyc = 0; cyc < 1200; cyc++) begin
      fill_phase   = ((cyc / 150) % 2) == 0;
      alloc_valid  = fill_phase ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
      alloc_pd_new = PREG_W'($urandom);
      alloc_pd_old = PREG_W'($urandom);
      alloc_pc     = $urandom;
      for (int i = 0; i < NUM_WB; i++) begin
        if ($urandom_range(0, 7) < (fill_phase ? 1 : 5)) begin
          if (q.size() > 0 && $urandom_range(0, 3) != 0)
            t = (m_head + $urandom_range(0, q.size() - 1)) % DEPTH;
          else
            t = $urandom_range(0, DEPTH - 1);
          wb_valid[i]              = 1'b1;
          wb_tag[i*TAG_W +: TAG_W] = TAG_W'(t);
        end
      end
      if (q.size() > 0 && $urandom_range(0, 24) == 0) begin
        flush_valid = 1'b1;
        flush_tag   = TAG_W'((m_head + $urandom_range(0, q.size() - 1)) % DEPTH);
      end
      #1;
      fl     = flush_valid;
      fpos   = m_pos(int'(flush_tag));
      n      = m_retire_n(fl, fpos);
      exp_rv = '0;
      for (int k = 0; k < n; k++) exp_rv[k] = 1'b1;
      n_checks++; if (retire_valid !== exp_rv) $display("FAIL rand_rv cyc %0d got %b want %b", cyc, retire_valid, exp_rv); else n_pass++;
      n_checks++; if (count !== 6'(q.size())) $display("FAIL rand_count cyc %0d got %0d want %0d", cyc, count, q.size()); else n_pass++;
      n_checks++; if (alloc_ready !== (q.size() < DEPTH && !fl)) $display("FAIL rand_alloc_ready cyc %0d got %0b want %0b", cyc, alloc_ready, (q.size() < DEPTH && !fl)); else n_pass++;
      n_checks++; if (alloc_tag !== 5'((m_head + q.size()) % DEPTH)) $display("FAIL rand_alloc_tag cyc %0d got %0d want %0d", cyc, alloc_tag, (m_head + q.size()) % DEPTH); else n_pass++;
      n_checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0)) $display("FAIL rand_full_empty cyc %0d got %0b%0b want %0b%0b", cyc, full, empty, q.size() == DEPTH, q.size() == 0); else n_pass++;
      for (int k = 0; k < n; k++) begin
        n_checks++;
        if (retire_pd_old[k*PREG_W +: PREG_W] !== q[k].pd_old || retire_pd_new[k*PREG_W +: PREG_W] !== q[k].pd_new ||
            retire_pc[k*32 +: 32] !== q[k].pc)
          $display("FAIL rand_lane%0d_data cyc %0d got %0d/%0d/%h want %0d/%0d/%h", k, cyc,
                   retire_pd_old[k*PREG_W +: PREG_W], retire_pd_new[k*PREG_W +: PREG_W], retire_pc[k*32 +: 32],
                   q[k].pd_old, q[k].pd_new, q[k].pc);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_inorder_retire();
    test_full();
    test_wrap();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
